// File: rtl/register_file_pkg.sv
// regfile_pkg: shared byte width and byte-merge helper for the register file.
// Word widths up to MAX_W are handled; callers extend operands and truncate the result.
package regfile_pkg;
    localparam int BYTE_W = 8;
    localparam int MAX_W  = 512;

    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0]        old_w,
        input logic [MAX_W-1:0]        new_w,
        input logic [MAX_W/BYTE_W-1:0] strb
    );
        logic [MAX_W-1:0] m;
        for (int i = 0; i < MAX_W/BYTE_W; i++)
            m[i*BYTE_W +: BYTE_W] = strb[i] ? new_w[i*BYTE_W +: BYTE_W] : old_w[i*BYTE_W +: BYTE_W];
        return m;
    endfunction
endpackage

// File: rtl/register_file_reg_word.sv
// reg_word: one DATA_W-bit register with per-byte write enables and synchronous reset.
module reg_word
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [DATA_W/BYTE_W-1:0] wstrb_i,
    output logic [DATA_W-1:0]        q_o
);
    logic [DATA_W-1:0] word_q, word_d;

    always_comb
        word_d = we_i ? DATA_W'(merge_bytes(MAX_W'(word_q), MAX_W'(wdata_i), (MAX_W/BYTE_W)'(wstrb_i)))
                      : word_q;

    always_ff @(posedge clk)
        word_q <= rst ? '0 : word_d;

    assign q_o = word_q;
endmodule

// File: rtl/register_file.sv
// register_file: DEPTH x DATA_W register bank, one byte-strobed write port, two read ports,
// optional hardwired-zero word 0, write-to-read bypass and registered read.
module register_file
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    parameter  int RD_REG   = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/BYTE_W-1:0] wstrb,
    input  logic [ADDR_W-1:0]        raddr_a,
    output logic [DATA_W-1:0]        rdata_a,
    input  logic [ADDR_W-1:0]        raddr_b,
    output logic [DATA_W-1:0]        rdata_b
);
    localparam int NW = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

    word_t         words [NW];
    logic [NW-1:0] live;
    word_t         merged, rd_a, rd_b;
    logic          hit_a, hit_b;

    // Unbacked slots (out of range, or hardwired zero) read as 0 and never take writes.
    for (genvar g = 0; g < NW; g++) begin : g_word
        if (g >= DEPTH || (ZERO_REG != 0 && g == 0)) begin : g_const
            assign words[g] = '0;
            assign live[g]  = 1'b0;
        end else begin : g_reg
            assign live[g] = 1'b1;
            reg_word #(.DATA_W(DATA_W)) u_word (
                .clk     (clk),
                .rst     (rst),
                .we_i    (we && waddr == ADDR_W'(g)),
                .wdata_i (wdata),
                .wstrb_i (wstrb),
                .q_o     (words[g])
            );
        end
    end

    always_comb begin
        merged = DATA_W'(merge_bytes(MAX_W'(words[waddr]), MAX_W'(wdata), (MAX_W/BYTE_W)'(wstrb)));
        hit_a  = BYPASS != 0 && we && live[waddr] && raddr_a == waddr;
        hit_b  = BYPASS != 0 && we && live[waddr] && raddr_b == waddr;
        rd_a   = hit_a ? merged : words[raddr_a];
        rd_b   = hit_b ? merged : words[raddr_b];
    end

    if (RD_REG != 0) begin : g_rd_reg
        word_t rdata_a_q, rdata_b_q;
        always_ff @(posedge clk) begin
            rdata_a_q <= rst ? '0 : rd_a;
            rdata_b_q <= rst ? '0 : rd_b;
        end
        assign rdata_a = rdata_a_q;
        assign rdata_b = rdata_b_q;
    end else begin : g_rd_comb
        assign rdata_a = rd_a;
        assign rdata_b = rd_b;
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: four configurations of register_file driven in lockstep and checked
// against a behavioural model; registered-read results go through a scoreboard queue.
module tb_register_file;
    logic        clk;
    logic        rst, we;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rd0a, rd0b, rd1a, rd1b, rd2a, rd2b, rd3a, rd3b;

    // u0: default, u1: no bypass, u2: registered read, u3: DEPTH=24
    register_file #(.DEPTH(32), .ZERO_REG(1), .BYPASS(1), .RD_REG(0)) u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(rd0a), .raddr_b(raddr_b), .rdata_b(rd0b));
    register_file #(.DEPTH(32), .ZERO_REG(1), .BYPASS(0), .RD_REG(0)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(rd1a), .raddr_b(raddr_b), .rdata_b(rd1b));
    register_file #(.DEPTH(32), .ZERO_REG(1), .BYPASS(1), .RD_REG(1)) u2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(rd2a), .raddr_b(raddr_b), .rdata_b(rd2b));
    register_file #(.DEPTH(24), .ZERO_REG(1), .BYPASS(1), .RD_REG(0)) u3 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(rd3a), .raddr_b(raddr_b), .rdata_b(rd3b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ce;
        logic [31:0] ev;
    } vec_t;

    vec_t        vq[$];
    logic [63:0] sbq[$];
    logic [31:0] mem   [32];
    logic [31:0] mem24 [32];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    function automatic logic [31:0] exp_rd(input bit d24, input bit byp, input logic [4:0] ra);
        logic [31:0] w;
        if (ra == 5'd0 || (d24 && ra >= 5'd24)) return 32'h0;
        w = d24 ? mem24[ra] : mem[ra];
        if (byp && we && waddr == ra) w = mrg(w, wdata, wstrb);
        return w;
    endfunction

    task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [4:0] ra, input logic [4:0] rb,
                        input logic ce, input logic [31:0] ev);
        logic [63:0] e;
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd; wstrb = ws; raddr_a = ra; raddr_b = rb;
        #1;
        if (ce) chk("vec_u0_a", rd0a, ev);
        if (!r) begin
            chk("u0_a", rd0a, exp_rd(0, 1, ra));
            chk("u0_b", rd0b, exp_rd(0, 1, rb));
            chk("u1_a", rd1a, exp_rd(0, 0, ra));
            chk("u1_b", rd1b, exp_rd(0, 0, rb));
            chk("u3_a", rd3a, exp_rd(1, 1, ra));
            chk("u3_b", rd3b, exp_rd(1, 1, rb));
        end
        sbq.push_back(r ? 64'h0 : {exp_rd(0, 1, ra), exp_rd(0, 1, rb)});
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            if (r) begin
                mem[i]   = 32'h0;
                mem24[i] = 32'h0;
            end else if (w && wa == 5'(i) && i != 0) begin
                mem[i] = mrg(mem[i], wd, ws);
                if (i < 24) mem24[i] = mrg(mem24[i], wd, ws);
            end
        end
        #1;
        e = sbq.pop_front();
        chk("u2_a", rd2a, e[63:32]);
        chk("u2_b", rd2b, e[31:0]);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0; raddr_a = '0; raddr_b = '0;
        for (int i = 0; i < 32; i++) begin mem[i] = 32'h0; mem24[i] = 32'h0; end
        //            r  w  wa     wd            ws       ra     rb     ce  ev
        vq.push_back('{1, 0, 5'd0,  32'h0,        4'h0,    5'd0,  5'd0,  0,  32'h0});
        vq.push_back('{0, 1, 5'd5,  32'hDEADBEEF, 4'hF,    5'd5,  5'd5,  1,  32'hDEADBEEF});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd5,  5'd5,  1,  32'hDEADBEEF});
        vq.push_back('{1, 1, 5'd3,  32'h12345678, 4'hF,    5'd5,  5'd3,  0,  32'h0});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd5,  5'd3,  1,  32'h0});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd3,  5'd5,  1,  32'h0});
        vq.push_back('{0, 1, 5'd7,  32'h11223344, 4'hF,    5'd7,  5'd7,  1,  32'h11223344});
        vq.push_back('{0, 1, 5'd7,  32'hAABBCCDD, 4'b0101, 5'd7,  5'd0,  1,  32'h11BB33DD});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd7,  5'd7,  1,  32'h11BB33DD});
        vq.push_back('{0, 1, 5'd7,  32'hFFFFFFFF, 4'h0,    5'd7,  5'd7,  1,  32'h11BB33DD});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd7,  5'd7,  1,  32'h11BB33DD});
        vq.push_back('{0, 1, 5'd0,  32'hFFFFFFFF, 4'hF,    5'd0,  5'd0,  1,  32'h0});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd0,  5'd0,  1,  32'h0});
        vq.push_back('{0, 1, 5'd9,  32'h12345678, 4'hF,    5'd9,  5'd9,  1,  32'h12345678});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd9,  5'd9,  1,  32'h12345678});
        vq.push_back('{0, 1, 5'd4,  32'hCAFE0004, 4'hF,    5'd4,  5'd9,  1,  32'hCAFE0004});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd4,  5'd4,  1,  32'hCAFE0004});
        vq.push_back('{0, 1, 5'd23, 32'h5A5A0023, 4'hF,    5'd23, 5'd23, 1,  32'h5A5A0023});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd23, 5'd23, 1,  32'h5A5A0023});
        vq.push_back('{0, 1, 5'd25, 32'h77777777, 4'hF,    5'd25, 5'd25, 1,  32'h77777777});
        vq.push_back('{0, 0, 5'd0,  32'h0,        4'h0,    5'd25, 5'd25, 1,  32'h77777777});
        foreach (vq[k])
            step(vq[k].r, vq[k].w, vq[k].wa, vq[k].wd, vq[k].ws, vq[k].ra, vq[k].rb, vq[k].ce, vq[k].ev);

        // fill, then a back-to-back read sweep with no idle cycles
        for (int i = 1; i < 32; i++)
            step(0, 1, 5'(i), 32'hC0DE0000 | 32'(i), 4'hF, 5'(i), 5'(i), 1, 32'hC0DE0000 | 32'(i));
        for (int i = 0; i < 32; i++)
            step(0, 0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i), 1, i == 0 ? 32'h0 : (32'hC0DE0000 | 32'(i)));

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ra, rb;
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
                 4'($urandom_range(0, 15)), ra, rb, 0, 32'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
